// File: rtl/mem_delay_injector.sv
// Avalon-MM pass-through that adds programmable read/write latency between a data master and a memory slave.
// Define MEM_DELAY_JITTER_EN to add LFSR-based jitter on top of the programmed delays.
module mem_delay_injector #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16,
   parameter int STAT_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [2:0]          csr_address,
   input  logic                csr_write,
   input  logic [31:0]         csr_writedata,
   input  logic                csr_read,
   output logic [31:0]         csr_readdata,
   input  logic [ADDR_W-1:0]   s_address,
   input  logic                s_read,
   input  logic                s_write,
   input  logic [DATA_W-1:0]   s_writedata,
   input  logic [DATA_W/8-1:0] s_byteenable,
   output logic [DATA_W-1:0]   s_readdata,
   output logic                s_waitrequest,
   output logic [ADDR_W-1:0]   m_address,
   output logic                m_read,
   output logic                m_write,
   output logic [DATA_W-1:0]   m_writedata,
   output logic [DATA_W/8-1:0] m_byteenable,
   input  logic [DATA_W-1:0]   m_readdata,
   input  logic                m_waitrequest
);

   typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, FWD = 2'd2} state_t;

   state_t              state_r, state_nxt_s;
   logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
   logic                enable_r;
   logic [CNT_W-1:0]    wr_delay_r, rd_delay_r;
   logic [STAT_W-1:0]   xact_r;
   logic [31:0]         csr_readdata_r, rd_mux_s;
   logic                req_s, xact_inc_s, m_read_s, m_write_s, s_wait_s;
   logic [CNT_W-1:0]    base_s, jitter_s, load_s;
   logic                unused_s;

   // Base + jitter, clamped to the counter's all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[CNT_W]) sat_add = {CNT_W{1'b1}};
      else            sat_add = sum[CNT_W-1:0];
   endfunction

   assign req_s  = s_read | s_write;
   assign base_s = s_write ? wr_delay_r : rd_delay_r;
   assign load_s = sat_add(base_s, jitter_s);

`ifdef MEM_DELAY_JITTER_EN
   localparam int LW = (CNT_W > 16) ? CNT_W : 16;
   logic             jitter_en_r;
   logic [CNT_W-1:0] jmask_r;
   logic [15:0]      lfsr_r;
   logic [LW-1:0]    lfsr_wide_s;

   assign lfsr_wide_s = LW'(lfsr_r);
   assign jitter_s    = jitter_en_r ? (lfsr_wide_s[CNT_W-1:0] & jmask_r) : {CNT_W{1'b0}};

   // Free-running Fibonacci LFSR, taps 16,14,13,11.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr_r <= 16'hACE1;
      else          lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
   end

   // Jitter control registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         jitter_en_r <= 1'b0;
         jmask_r     <= {CNT_W{1'b0}};
      end else if (csr_write && csr_address == 3'd0) begin
         jitter_en_r <= csr_writedata[1];
      end else if (csr_write && csr_address == 3'd3) begin
         jmask_r     <= csr_writedata[CNT_W-1:0];
      end else begin
         jitter_en_r <= jitter_en_r;
      end
   end
`else
   assign jitter_s = {CNT_W{1'b0}};
`endif

   assign unused_s = ^{csr_writedata};

   // Core CSRs and the saturating transaction counter; a clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_r   <= 1'b0;
         wr_delay_r <= {CNT_W{1'b0}};
         rd_delay_r <= {CNT_W{1'b0}};
         xact_r     <= {STAT_W{1'b0}};
      end else begin
         if (csr_write && csr_address == 3'd0) enable_r   <= csr_writedata[0];
         if (csr_write && csr_address == 3'd1) wr_delay_r <= csr_writedata[CNT_W-1:0];
         if (csr_write && csr_address == 3'd2) rd_delay_r <= csr_writedata[CNT_W-1:0];
         if (csr_write && csr_address == 3'd4)                xact_r <= {STAT_W{1'b0}};
         else if (xact_inc_s && xact_r != {STAT_W{1'b1}})     xact_r <= xact_r + STAT_W'(1);
         else                                                 xact_r <= xact_r;
      end
   end

   // CSR readback mux, built from pre-write register values.
   always_comb begin
      rd_mux_s = 32'h0000_0000;
      case (csr_address)
`ifdef MEM_DELAY_JITTER_EN
         3'd0: rd_mux_s = {30'd0, jitter_en_r, enable_r};
         3'd3: rd_mux_s = 32'(jmask_r);
`else
         3'd0: rd_mux_s = {31'd0, enable_r};
         3'd3: rd_mux_s = 32'h0000_0000;
`endif
         3'd1: rd_mux_s = 32'(wr_delay_r);
         3'd2: rd_mux_s = 32'(rd_delay_r);
         3'd4: rd_mux_s = 32'(xact_r);
         3'd5: rd_mux_s = {31'd0, state_r != IDLE};
         default: rd_mux_s = 32'h0000_0000;
      endcase
   end

   // Registered CSR read data, held between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      csr_readdata_r <= 32'h0000_0000;
      else if (csr_read) csr_readdata_r <= rd_mux_s;
      else               csr_readdata_r <= csr_readdata_r;
   end

   // FSM state and delay counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next state and strobe gating; defaults give the transparent path.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      xact_inc_s  = 1'b0;
      m_read_s    = s_read;
      m_write_s   = s_write;
      s_wait_s    = m_waitrequest;
      case (state_r)
         IDLE: begin
            if (enable_r) begin
               m_read_s  = 1'b0;
               m_write_s = 1'b0;
               s_wait_s  = req_s;
               if (req_s) begin
                  cnt_nxt_s   = load_s;
                  state_nxt_s = (load_s != {CNT_W{1'b0}}) ? DELAY : FWD;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DELAY: begin
            m_read_s  = 1'b0;
            m_write_s = 1'b0;
            s_wait_s  = 1'b1;
            cnt_nxt_s = cnt_r - CNT_W'(1);
            if (!req_s)                      state_nxt_s = IDLE;
            else if (cnt_r == CNT_W'(1))     state_nxt_s = FWD;
            else                             state_nxt_s = DELAY;
         end
         FWD: begin
            // A read+write collision is forwarded as a write only.
            m_read_s = s_read & ~s_write;
            if (!req_s) begin
               state_nxt_s = IDLE;
            end else if (!m_waitrequest) begin
               xact_inc_s  = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = FWD;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   assign csr_readdata  = csr_readdata_r;
   assign m_address     = s_address;
   assign m_writedata   = s_writedata;
   assign m_byteenable  = s_byteenable;
   assign m_read        = m_read_s;
   assign m_write       = m_write_s;
   assign s_waitrequest = s_wait_s;
   assign s_readdata    = m_readdata;

endmodule
